// File: rtl/us_scan_scheduler.sv
// rtl/us_scan_scheduler.sv - ultrasound multi-channel transmit/receive scan scheduler
// Steps enabled channels through select/excite/blank/acquire and repeats frames on a fixed period.
module us_scan_scheduler #(
    parameter int CH_NUM      = 4,
    parameter int SETTLE_CYC  = 50,
    parameter int BLANK_CYC   = 100,
    parameter int TIMEOUT_CYC = 500_000,
    parameter int PERIOD_CYC  = 200_000_000
) (
    input  logic                      clk_50M,
    input  logic                      rst,
    input  logic [2:0]                command,
    input  logic [CH_NUM-1:0]         ch_mask,
    input  logic                      ad_done,
    output logic [CH_NUM-1:0]         ch_sel,
    output logic [$clog2(CH_NUM)-1:0] cur_ch,
    output logic                      Exc_start,
    output logic                      AD_start,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      timeout_err
);
    localparam int CW      = $clog2(CH_NUM);
    localparam int SB_MAX  = (SETTLE_CYC > BLANK_CYC) ? SETTLE_CYC : BLANK_CYC;
    localparam int CNT_MAX = (SB_MAX > TIMEOUT_CYC) ? SB_MAX : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PER_W   = $clog2(PERIOD_CYC + 1);

    localparam logic [2:0] CMD_CONT   = 3'h1;
    localparam logic [2:0] CMD_SINGLE = 3'h2;
    localparam logic [2:0] CMD_STOP   = 3'h3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EXC,
        S_BLANK,
        S_ACQ,
        S_WAIT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_cont;
    logic [CH_NUM-1:0]  r_mask;
    logic [CW-1:0]      r_ch;
    logic [CNT_W-1:0]   r_cnt;
    logic [PER_W-1:0]   r_per;
    logic               r_stop_req;
    logic [CH_NUM-1:0]  r_ch_sel;
    logic [CW-1:0]      r_cur_ch;
    logic               r_exc;
    logic               r_ad;
    logic               r_busy;
    logic               r_frame_done;
    logic               r_timeout;

    logic               w_cont_nxt;
    logic [CH_NUM-1:0]  w_mask_nxt;
    logic [CW-1:0]      w_ch_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [PER_W-1:0]   w_per_nxt;
    logic               w_stop_nxt;
    logic               w_fd_nxt;
    logic               w_to_set;
    logic               w_to_clr;
    logic               w_begin;
    logic               w_begin_cont;
    logic [CW-1:0]      w_first_ch;
    logic [CW-1:0]      w_next_ch;
    logic               w_next_vld;
    logic               w_active_now;
    logic               w_acq_done;
    logic               w_acq_tmo;

    logic               w_active;
    logic [CH_NUM-1:0]  w_ch_sel_nxt;
    logic [CW-1:0]      w_cur_ch_nxt;
    logic               w_exc_nxt;
    logic               w_ad_nxt;
    logic               w_busy_nxt;
    logic               w_timeout_nxt;

    // Lowest enabled channel of the live mask (used only at frame start).
    always_comb begin
        w_first_ch = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (ch_mask[i]) w_first_ch = CW'(i);
        end
    end

    always_comb begin
        w_next_ch  = '0;
        w_next_vld = 1'b0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (r_mask[i] && (i > int'(r_ch))) begin
                w_next_ch  = CW'(i);
                w_next_vld = 1'b1;
            end
        end
    end

    assign w_active_now = (r_state == S_SELECT) || (r_state == S_EXC) ||
                          (r_state == S_BLANK)  || (r_state == S_ACQ);
    // ad_done in the AD_start cycle is too early to be a real completion.
    assign w_acq_done   = (r_cnt != '0) && ad_done;
    assign w_acq_tmo    = !w_acq_done && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cont_nxt   = r_cont;
        w_mask_nxt   = r_mask;
        w_ch_nxt     = r_ch;
        w_cnt_nxt    = r_cnt + 1'b1;
        w_per_nxt    = (r_per == PER_W'(PERIOD_CYC)) ? r_per : r_per + 1'b1;
        w_stop_nxt   = r_stop_req | (w_active_now && (command == CMD_STOP));
        w_fd_nxt     = 1'b0;
        w_to_set     = 1'b0;
        w_to_clr     = 1'b0;
        w_begin      = 1'b0;
        w_begin_cont = r_cont;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if ((command == CMD_CONT) || (command == CMD_SINGLE)) begin
                    w_begin      = 1'b1;
                    w_begin_cont = (command == CMD_CONT);
                    w_to_clr     = 1'b1;
                end
            end
            S_SELECT: begin
                if (r_cnt == CNT_W'(SETTLE_CYC - 1)) begin
                    w_state_nxt = S_EXC;
                    w_cnt_nxt   = '0;
                end
            end
            S_EXC: begin
                w_state_nxt = S_BLANK;
                w_cnt_nxt   = '0;
            end
            S_BLANK: begin
                if (r_cnt == CNT_W'(BLANK_CYC - 1)) begin
                    w_state_nxt = S_ACQ;
                    w_cnt_nxt   = '0;
                end
            end
            S_ACQ: begin
                if (w_acq_done || w_acq_tmo) begin
                    w_cnt_nxt = '0;
                    w_to_set  = w_acq_tmo;
                    if (w_stop_nxt) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_next_vld) begin
                        w_state_nxt = S_SELECT;
                        w_ch_nxt    = w_next_ch;
                    end else begin
                        w_fd_nxt    = 1'b1;
                        w_state_nxt = r_cont ? S_WAIT : S_IDLE;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = '0;
                if (command == CMD_STOP)                       w_state_nxt = S_IDLE;
                else if (r_per >= PER_W'(PERIOD_CYC - 1))      w_begin     = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Frame start: an empty mask completes the frame immediately.
        if (w_begin) begin
            w_cont_nxt = w_begin_cont;
            w_mask_nxt = ch_mask;
            w_per_nxt  = '0;
            w_cnt_nxt  = '0;
            if (|ch_mask) begin
                w_state_nxt = S_SELECT;
                w_ch_nxt    = w_first_ch;
            end else begin
                w_fd_nxt    = 1'b1;
                w_state_nxt = w_begin_cont ? S_WAIT : S_IDLE;
            end
        end
        if ((w_state_nxt == S_IDLE) || (w_state_nxt == S_WAIT)) w_stop_nxt = 1'b0;
    end

    always_comb begin
        w_active      = (w_state_nxt == S_SELECT) || (w_state_nxt == S_EXC) ||
                        (w_state_nxt == S_BLANK)  || (w_state_nxt == S_ACQ);
        w_ch_sel_nxt  = w_active ? (CH_NUM'(1) << w_ch_nxt) : '0;
        w_cur_ch_nxt  = w_active ? w_ch_nxt : '0;
        w_exc_nxt     = (w_state_nxt == S_EXC);
        w_ad_nxt      = (w_state_nxt == S_ACQ) && (r_state == S_BLANK);
        // busy also covers the frame_done cycle so it drops one cycle after it.
        w_busy_nxt    = (w_state_nxt != S_IDLE) || w_fd_nxt;
        w_timeout_nxt = w_to_clr ? 1'b0 : (r_timeout | w_to_set);
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            r_cont       <= 1'b0;
            r_mask       <= '0;
            r_ch         <= '0;
            r_cnt        <= '0;
            r_per        <= '0;
            r_stop_req   <= 1'b0;
            r_ch_sel     <= '0;
            r_cur_ch     <= '0;
            r_exc        <= 1'b0;
            r_ad         <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_cont       <= w_cont_nxt;
            r_mask       <= w_mask_nxt;
            r_ch         <= w_ch_nxt;
            r_cnt        <= w_cnt_nxt;
            r_per        <= w_per_nxt;
            r_stop_req   <= w_stop_nxt;
            r_ch_sel     <= w_ch_sel_nxt;
            r_cur_ch     <= w_cur_ch_nxt;
            r_exc        <= w_exc_nxt;
            r_ad         <= w_ad_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_fd_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    assign ch_sel      = r_ch_sel;
    assign cur_ch      = r_cur_ch;
    assign Exc_start   = r_exc;
    assign AD_start    = r_ad;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign timeout_err = r_timeout;

endmodule

// File: tb/tb_us_scan_scheduler.sv
// tb/tb_us_scan_scheduler.sv - scoreboard bench for us_scan_scheduler
module tb_us_scan_scheduler;
    localparam int S  = 4;
    localparam int B  = 8;
    localparam int TO = 32;
    localparam int P  = 400;
    localparam int K_EXC = 0, K_AD = 1, K_FD = 2, K_TO = 3;

    logic       clk_50M = 1'b0;
    logic       rst     = 1'b1;
    logic [2:0] command = 3'd0;
    logic [3:0] ch_mask = 4'd0;
    logic       ad_done = 1'b0;
    logic [3:0] ch_sel;
    logic [1:0] cur_ch;
    logic       Exc_start, AD_start, busy, frame_done, timeout_err;

    us_scan_scheduler #(
        .CH_NUM(4), .SETTLE_CYC(S), .BLANK_CYC(B), .TIMEOUT_CYC(TO), .PERIOD_CYC(P)
    ) dut (
        .clk_50M(clk_50M), .rst(rst), .command(command), .ch_mask(ch_mask),
        .ad_done(ad_done), .ch_sel(ch_sel), .cur_ch(cur_ch), .Exc_start(Exc_start),
        .AD_start(AD_start), .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
    );

    always #10 clk_50M = ~clk_50M;

    int cyc = 0;
    always @(posedge clk_50M) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        int         cyc;
        logic [3:0] ch;
        int         idx;
    } ev_t;

    ev_t  exp_q[$];
    int   dly_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    bit   to_flag  = 1'b0;
    int   pending  = -1;
    logic to_prev  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int k, input int c, input int ch, input int cut);
        ev_t e;
        if (c < cut) begin
            e.kind = k;
            e.cyc  = c;
            e.ch   = (k == K_EXC || k == K_AD) ? 4'(1 << ch) : 4'd0;
            e.idx  = (k == K_EXC || k == K_AD) ? ch : 0;
            exp_q.push_back(e);
        end
    endtask

    // Frame model: a start decided at cycle t puts the channel in SELECT at t+1; each
    // channel ends on its ad_done cycle (or at AD+TO-1) and the next one is decided there.
    task automatic model_frame(input int t, input logic [3:0] m, input int d[4],
                               input int stop_after, input int cut, output int fd);
        int s, n, exc, ad, e;
        s  = t;
        n  = 0;
        fd = -1;
        for (int ch = 0; ch < 4; ch++) begin
            if (m[ch]) begin
                exc = s + S + 1;
                ad  = exc + B + 1;
                push_ev(K_EXC, exc, ch, cut);
                push_ev(K_AD, ad, ch, cut);
                if (ad < cut) dly_q.push_back(d[ch]);
                if (d[ch] != 0) begin
                    e = ad + d[ch];
                end else begin
                    e = ad + TO - 1;
                    if (!to_flag) push_ev(K_TO, e + 1, 0, cut);
                    to_flag = 1'b1;
                end
                s = e;
                n++;
                if (n == stop_after) return;
            end
        end
        push_ev(K_FD, s + 1, 0, cut);
        fd = s + 1;
    endtask

    task automatic check_ev(input int k, input logic [3:0] cs, input logic [1:0] ci);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d ch_sel %b, none expected", k, cyc, cs);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.ch != cs || e.idx != int'(ci)) begin
                n_err++;
                $display("FAIL event: got kind %0d cycle %0d ch_sel %b cur_ch %0d, expected kind %0d cycle %0d ch_sel %b cur_ch %0d",
                         k, cyc, cs, ci, e.kind, e.cyc, e.ch, e.idx);
            end
        end
    endtask

    // Monitor: every output pulse is matched against the head of the scoreboard.
    always @(negedge clk_50M) begin
        if (!rst) begin
            if (Exc_start)                check_ev(K_EXC, ch_sel, cur_ch);
            if (AD_start)                 check_ev(K_AD, ch_sel, cur_ch);
            if (timeout_err && !to_prev)  check_ev(K_TO, 4'd0, 2'd0);
            if (frame_done)               check_ev(K_FD, 4'd0, 2'd0);
            to_prev = timeout_err;
        end else begin
            to_prev = 1'b0;
        end
    end

    // AD capture responder: ad_done follows each AD_start by the queued delay (0 = never).
    always @(negedge clk_50M) begin
        if (rst) begin
            pending = -1;
            ad_done = 1'b0;
        end else begin
            if (AD_start) begin
                if (dly_q.size() != 0) pending = cyc + dly_q.pop_front();
                else                   pending = -1;
                if (pending == cyc) pending = -1;
            end
            ad_done = (cyc == pending);
        end
    end

    task automatic at_cycle(input int c);
        while (cyc < c) @(negedge clk_50M);
    endtask

    task automatic start_cmd(input logic [2:0] c, input logic [3:0] m, output int t);
        @(negedge clk_50M);
        ch_mask = m;
        command = c;
        t       = cyc;
        to_flag = 1'b0;
    endtask

    task automatic end_cmd();
        @(negedge clk_50M);
        command = 3'd0;
    endtask

    task automatic pulse_cmd(input logic [2:0] c);
        command = c;
        @(negedge clk_50M);
        command = 3'd0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < budget) begin
            @(negedge clk_50M);
            b++;
        end
        check({name, "_pending_events"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk_50M);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ch_sel"}, int'(ch_sel), 0);
        check({name, "_cur_ch"}, int'(cur_ch), 0);
        check({name, "_exc"}, int'(Exc_start), 0);
        check({name, "_ad"}, int'(AD_start), 0);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_frame_done"}, int'(frame_done), 0);
        check({name, "_timeout_err"}, int'(timeout_err), 0);
    endtask

    initial begin
        int         t, t2, t3, fd, fd1, fd2, fd3;
        int         dv[4];
        logic [3:0] mf[3];
        int         df[3][4];
        logic [3:0] m;

        // Reset at start with a start command present: must be ignored.
        command = 3'd1;
        ch_mask = 4'hF;
        repeat (3) @(negedge clk_50M);
        check_all_zero("reset_start");
        command = 3'd0;
        rst     = 1'b0;
        repeat (2) @(negedge clk_50M);
        check("idle_busy", int'(busy), 0);

        // Single frame, mask 1011, ad_done 5 cycles after each AD_start.
        dv = '{5, 5, 5, 5};
        start_cmd(3'd2, 4'b1011, t);
        model_frame(t, 4'b1011, dv, -1, 1 << 30, fd);
        end_cmd();
        check("single_busy_t1", int'(busy), 1);
        check("single_ch_sel_t1", int'(ch_sel), 1);
        wait_drain("single", 500);
        check("single_busy_after", int'(busy), 0);

        // Timeout on ch2; sequencing continues on ch3; flag is sticky.
        dv = '{5, 5, 0, 5};
        start_cmd(3'd2, 4'b1111, t);
        model_frame(t, 4'b1111, dv, -1, 1 << 30, fd);
        end_cmd();
        wait_drain("timeout", 800);
        repeat (10) @(negedge clk_50M);
        check("timeout_sticky", int'(timeout_err), 1);

        // Empty mask single frame: frame_done at T+1 only; also clears timeout_err.
        dv = '{5, 5, 5, 5};
        start_cmd(3'd2, 4'b0000, t);
        model_frame(t, 4'b0000, dv, -1, 1 << 30, fd);
        end_cmd();
        check("timeout_cleared", int'(timeout_err), 0);
        wait_drain("mask_zero", 50);

        // Randomized single frames, including ad_done at the last legal cycle.
        for (int it = 0; it < 6; it++) begin
            m = 4'($urandom_range(0, 15));
            for (int c = 0; c < 4; c++)
                dv[c] = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, TO - 1));
            if (it == 0) dv = '{1, TO - 1, 1, TO - 1};
            start_cmd(3'd2, m, t);
            model_frame(t, m, dv, -1, 1 << 30, fd);
            end_cmd();
            wait_drain("random_single", 800);
            check("random_busy_after", int'(busy), 0);
        end

        // Continuous: three frames P apart, mask changed mid-frame, then stop in WAIT_PERIOD.
        for (int f = 0; f < 3; f++) begin
            mf[f] = 4'($urandom_range(1, 15));
            for (int c = 0; c < 4; c++)
                df[f][c] = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, TO - 1));
        end
        mf[0] = 4'b1111;
        start_cmd(3'd1, mf[0], t);
        model_frame(t, mf[0], df[0], -1, 1 << 30, fd1);
        t2 = (t + P > fd1) ? t + P : fd1;
        model_frame(t2, mf[1], df[1], -1, 1 << 30, fd2);
        t3 = (t2 + P > fd2) ? t2 + P : fd2;
        model_frame(t3, mf[2], df[2], -1, 1 << 30, fd3);
        end_cmd();
        at_cycle(t + 11);
        ch_mask = mf[1];
        at_cycle(t2 + 11);
        ch_mask = mf[2];
        at_cycle(t3 + 11);
        ch_mask = 4'($urandom_range(0, 15));
        wait_drain("continuous", 3000);
        at_cycle(fd3 + 4);
        pulse_cmd(3'd3);
        @(negedge clk_50M);
        check("cont_stop_busy", int'(busy), 0);
        at_cycle(t3 + P + 20);
        check("cont_no_restart_busy", int'(busy), 0);

        // Stop during BLANK of ch1: ch1 completes, nothing after it.
        dv = '{5, 5, 5, 5};
        start_cmd(3'd2, 4'b1111, t);
        model_frame(t, 4'b1111, dv, 2, 1 << 30, fd);
        end_cmd();
        at_cycle(t + (S + B + 2 + 5) + S + 1 + 3);
        pulse_cmd(3'd3);
        wait_drain("stop_blank", 200);
        repeat (20) @(negedge clk_50M);
        check("stop_busy_after", int'(busy), 0);

        // Reset mid-BLANK of ch1 (first enabled), then a clean continuous restart.
        start_cmd(3'd2, 4'b0110, t);
        model_frame(t, 4'b0110, dv, -1, t + 8, fd);
        end_cmd();
        at_cycle(t + 8);
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid");
        command = 3'd1;
        repeat (2) @(negedge clk_50M);
        check("reset_cmd_ignored_busy", int'(busy), 0);
        dly_q.delete();
        exp_q.delete();
        command = 3'd0;
        rst     = 1'b0;
        @(negedge clk_50M);
        dv = '{3, 4, 6, 2};
        start_cmd(3'd1, 4'b0110, t);
        model_frame(t, 4'b0110, dv, -1, 1 << 30, fd);
        end_cmd();
        wait_drain("restart", 300);
        at_cycle(fd + 3);
        pulse_cmd(3'd3);
        @(negedge clk_50M);
        check("restart_stop_busy", int'(busy), 0);
        at_cycle(t + P + 20);
        check("final_ch_sel", int'(ch_sel), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #(20 * 20000);
        $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
